// File: rtl/multicycle_control_fsm_if.sv
// Control/handshake bundle between the multi-cycle sequencer (master) and the RV32I datapath (slave).
// Carries IR opcode, ALU zero and memory ready inward; all datapath/memory strobes outward.
interface multicycle_control_fsm_if;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal_instr;
    logic       bus_err;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
               wb_sel, alu_src_a, alu_src_b, alu_op, instr_done, illegal_instr, bus_err
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
               wb_sel, alu_src_a, alu_src_b, alu_op, instr_done, illegal_instr, bus_err
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencer: 3 (branch/JAL), 4 (R/I/store), 5 (load) cycles, +1 per mem_ready wait cycle.
// Stalls in FETCH/MEM until mem_ready, bounded by TIMEOUT; `CTRL_PERF_CNT_EN adds retired_cnt.
module multicycle_control_fsm #(
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_control_fsm_if.master bus
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]            retired_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_src;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       illegal_instr;
        logic       bus_err;
    } ctrl_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic [6:0] op_q;
    logic [7:0] wait_cnt;
    logic       waiting;
    logic       timeout;
    logic       opcode_legal;
    ctrl_t      ctl;

    assign waiting = (state == FETCH) || (state == MEM);
    // mem_ready has priority: a late ready on the last allowed cycle still completes
    assign timeout = waiting && !bus.mem_ready && (wait_cnt == WAIT_LAST);

    always_comb begin
        opcode_legal = 1'b0;
        case (bus.opcode)
            OP_R, OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_JAL: opcode_legal = 1'b1;
            default:                                            opcode_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q <= 7'd0;
        end else if (state == DECODE) begin
            op_q <= bus.opcode;
        end
    end

    // Cleared on every entry to a wait state, including the FETCH retry after a timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 8'd0;
        end else if (((state_next == FETCH) || (state_next == MEM)) &&
                     ((state_next != state) || timeout)) begin
            wait_cnt <= 8'd0;
        end else if (waiting && !bus.mem_ready) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_comb begin
        ctl        = '0;
        state_next = state;
        unique case (state)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = 2'b01;
                if (bus.mem_ready) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    state_next   = DECODE;
                end else if (timeout) begin
                    ctl.bus_err    = 1'b1;
                    ctl.instr_done = 1'b1;
                    state_next     = FETCH;
                end
            end
            DECODE: begin
                // ALU computes oldPC + imm so the target is registered for branch/JAL
                ctl.alu_src_b = 2'b10;
                if (opcode_legal) begin
                    state_next = EXEC;
                end else begin
                    ctl.illegal_instr = 1'b1;
                    ctl.instr_done    = 1'b1;
                    state_next        = FETCH;
                end
            end
            EXEC: begin
                state_next = FETCH;
                case (op_q)
                    OP_R: begin
                        ctl.alu_src_a = 1'b1;
                        ctl.alu_src_b = 2'b00;
                        ctl.alu_op    = 2'b10;
                        state_next    = WB;
                    end
                    OP_IMM: begin
                        ctl.alu_src_a = 1'b1;
                        ctl.alu_src_b = 2'b10;
                        ctl.alu_op    = 2'b10;
                        state_next    = WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        ctl.alu_src_a = 1'b1;
                        ctl.alu_src_b = 2'b10;
                        ctl.alu_op    = 2'b00;
                        state_next    = MEM;
                    end
                    OP_BRANCH: begin
                        ctl.alu_src_a  = 1'b1;
                        ctl.alu_src_b  = 2'b00;
                        ctl.alu_op     = 2'b01;
                        ctl.pc_write   = bus.zero;
                        ctl.pc_src     = bus.zero;
                        ctl.instr_done = 1'b1;
                    end
                    OP_JAL: begin
                        ctl.pc_write   = 1'b1;
                        ctl.pc_src     = 1'b1;
                        ctl.reg_write  = 1'b1;
                        ctl.wb_sel     = 2'b10;
                        ctl.instr_done = 1'b1;
                    end
                    default: begin
                        state_next = FETCH;
                    end
                endcase
            end
            MEM: begin
                ctl.iord = 1'b1;
                if (op_q == OP_LOAD) begin
                    ctl.mem_read = 1'b1;
                end else begin
                    ctl.mem_write = 1'b1;
                end
                if (bus.mem_ready) begin
                    if (op_q == OP_LOAD) begin
                        state_next = WB;
                    end else begin
                        ctl.instr_done = 1'b1;
                        state_next     = FETCH;
                    end
                end else if (timeout) begin
                    ctl.bus_err    = 1'b1;
                    ctl.instr_done = 1'b1;
                    state_next     = FETCH;
                end
            end
            WB: begin
                ctl.reg_write  = 1'b1;
                ctl.wb_sel     = (op_q == OP_LOAD) ? 2'b01 : 2'b00;
                ctl.instr_done = 1'b1;
                state_next     = FETCH;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.pc_write      = ctl.pc_write;
    assign bus.pc_src        = ctl.pc_src;
    assign bus.ir_write      = ctl.ir_write;
    assign bus.iord          = ctl.iord;
    assign bus.mem_read      = ctl.mem_read;
    assign bus.mem_write     = ctl.mem_write;
    assign bus.reg_write     = ctl.reg_write;
    assign bus.wb_sel        = ctl.wb_sel;
    assign bus.alu_src_a     = ctl.alu_src_a;
    assign bus.alu_src_b     = ctl.alu_src_b;
    assign bus.alu_op        = ctl.alu_op;
    assign bus.instr_done    = ctl.instr_done;
    assign bus.illegal_instr = ctl.illegal_instr;
    assign bus.bus_err       = ctl.bus_err;

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_cnt <= 32'd0;
        end else if (ctl.instr_done && !ctl.bus_err && !ctl.illegal_instr) begin
            retired_cnt <= retired_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: per-cycle expected control vectors from a spec model.
module tb_multicycle_control_fsm;

    localparam int TIMEOUT = 16;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    typedef enum {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} tst_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_src;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       illegal_instr;
        logic       bus_err;
    } ctl_t;

    typedef struct {
        tst_e       st;
        logic [6:0] opc;
        logic       z;
        logic       rdy;
    } cyc_t;

    logic clk = 1'b0;
    logic reset;
    multicycle_control_fsm_if bus ();
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] retired_cnt;
`endif

    multicycle_control_fsm #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef CTRL_PERF_CNT_EN
        ,
        .retired_cnt (retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   errors  = 0;
    ctl_t sb[$];
    tst_e prev_st     = S_IDLE;
    logic prev_to     = 1'b0;
    int   wait_m      = 0;
    logic [6:0] op_m  = 7'd0;
    int   exp_retired = 0;

    function automatic cyc_t c(tst_e st, logic [6:0] opc, logic z, logic rdy);
        cyc_t r;
        r.st = st; r.opc = opc; r.z = z; r.rdy = rdy;
        return r;
    endfunction

    function automatic logic legal(logic [6:0] op);
        return (op == OP_R) || (op == OP_LOAD) || (op == OP_IMM) ||
               (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JAL);
    endfunction

    // Reference control table, taken state by state from the behavioural description
    function automatic ctl_t model(tst_e st, logic [6:0] opc, logic z, logic rdy, logic to);
        ctl_t e = '0;
        case (st)
            S_FETCH: begin
                e.mem_read = 1'b1; e.alu_src_b = 2'b01;
                if (rdy) begin e.ir_write = 1'b1; e.pc_write = 1'b1; end
                else if (to) begin e.bus_err = 1'b1; e.instr_done = 1'b1; end
            end
            S_DECODE: begin
                e.alu_src_b = 2'b10;
                if (!legal(opc)) begin e.illegal_instr = 1'b1; e.instr_done = 1'b1; end
            end
            S_EXEC: begin
                if (op_m == OP_R) begin e.alu_src_a = 1'b1; e.alu_op = 2'b10; end
                if (op_m == OP_IMM) begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 2'b10; end
                if (op_m == OP_LOAD || op_m == OP_STORE) begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
                if (op_m == OP_BRANCH) begin
                    e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.instr_done = 1'b1;
                    e.pc_write = z; e.pc_src = z;
                end
                if (op_m == OP_JAL) begin
                    e.pc_write = 1'b1; e.pc_src = 1'b1; e.reg_write = 1'b1;
                    e.wb_sel = 2'b10; e.instr_done = 1'b1;
                end
            end
            S_MEM: begin
                e.iord = 1'b1;
                if (op_m == OP_LOAD) e.mem_read = 1'b1; else e.mem_write = 1'b1;
                if (rdy) e.instr_done = (op_m == OP_STORE);
                else if (to) begin e.bus_err = 1'b1; e.instr_done = 1'b1; end
            end
            S_WB: begin
                e.reg_write = 1'b1; e.instr_done = 1'b1;
                e.wb_sel = (op_m == OP_LOAD) ? 2'b01 : 2'b00;
            end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic ctl_t outs();
        ctl_t o;
        o.pc_write = bus.pc_write;   o.pc_src = bus.pc_src;       o.ir_write = bus.ir_write;
        o.iord = bus.iord;           o.mem_read = bus.mem_read;   o.mem_write = bus.mem_write;
        o.reg_write = bus.reg_write; o.wb_sel = bus.wb_sel;       o.alu_src_a = bus.alu_src_a;
        o.alu_src_b = bus.alu_src_b; o.alu_op = bus.alu_op;       o.instr_done = bus.instr_done;
        o.illegal_instr = bus.illegal_instr; o.bus_err = bus.bus_err;
        return o;
    endfunction

    task automatic model_reset();
        prev_st = S_IDLE; prev_to = 1'b0; wait_m = 0; op_m = 7'd0; exp_retired = 0;
    endtask

    // Drives one cycle's inputs, pushes its expected vector, and moves to the sampling edge
    task automatic drive(cyc_t cy);
        logic to;
        ctl_t e;
        bus.opcode = cy.opc; bus.zero = cy.z; bus.mem_ready = cy.rdy;
        if ((cy.st == S_FETCH || cy.st == S_MEM) && (cy.st != prev_st || prev_to)) wait_m = 0;
        to = (cy.st == S_FETCH || cy.st == S_MEM) && !cy.rdy && (wait_m == TIMEOUT - 1);
        e = model(cy.st, cy.opc, cy.z, cy.rdy, to);
        sb.push_back(e);
        if (cy.st == S_DECODE) op_m = cy.opc;
        if ((cy.st == S_FETCH || cy.st == S_MEM) && !cy.rdy) wait_m++;
        if (e.instr_done && !e.bus_err && !e.illegal_instr && !reset) exp_retired++;
        prev_st = cy.st; prev_to = to;
        @(negedge clk);
    endtask

    task automatic test_reset();
        cyc_t cy[$];
        ctl_t obs, exp;
        cy.push_back(c(S_IDLE, OP_R, 1'b1, 1'b1)); cy.push_back(c(S_IDLE, OP_JAL, 1'b1, 1'b1));
        foreach (cy[i]) begin
            drive(cy[i]);
            obs = outs(); exp = sb.pop_front(); vectors++;
            if (obs !== exp) begin errors++; $display("FAIL reset[%0d]: got %b want %b", i, obs, exp); end
            @(posedge clk); #1;
        end
`ifdef CTRL_PERF_CNT_EN
        vectors++;
        if (retired_cnt !== 32'd0) begin errors++; $display("FAIL reset_retired: got %0d want 0", retired_cnt); end
`endif
        reset = 1'b0;
    endtask

    task automatic test_r_type();
        cyc_t cy[$];
        ctl_t obs, exp;
        cy.push_back(c(S_IDLE, OP_R, 0, 1));   cy.push_back(c(S_FETCH, OP_R, 0, 1));
        cy.push_back(c(S_DECODE, OP_R, 0, 1)); cy.push_back(c(S_EXEC, OP_R, 0, 1));
        cy.push_back(c(S_WB, OP_R, 0, 1));
        foreach (cy[i]) begin
            drive(cy[i]);
            obs = outs(); exp = sb.pop_front(); vectors++;
            if (obs !== exp) begin errors++; $display("FAIL r_type[%0d]: got %b want %b", i, obs, exp); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_wait();
        cyc_t cy[$];
        ctl_t obs, exp;
        cy.push_back(c(S_FETCH, OP_R, 0, 1)); cy.push_back(c(S_DECODE, OP_LOAD, 0, 1));
        cy.push_back(c(S_EXEC, OP_R, 0, 1));
        for (int k = 0; k < 3; k++) cy.push_back(c(S_MEM, OP_STORE, 0, 0));
        cy.push_back(c(S_MEM, OP_R, 0, 1));   cy.push_back(c(S_WB, OP_JAL, 0, 1));
        foreach (cy[i]) begin
            drive(cy[i]);
            obs = outs(); exp = sb.pop_front(); vectors++;
            if (obs !== exp) begin errors++; $display("FAIL load_wait[%0d]: got %b want %b", i, obs, exp); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_jal();
        cyc_t cy[$];
        ctl_t obs, exp;
        cy.push_back(c(S_FETCH, OP_R, 0, 1)); cy.push_back(c(S_DECODE, OP_BRANCH, 0, 1));
        cy.push_back(c(S_EXEC, OP_LOAD, 1, 1));
        cy.push_back(c(S_FETCH, OP_R, 1, 1)); cy.push_back(c(S_DECODE, OP_BRANCH, 1, 1));
        cy.push_back(c(S_EXEC, OP_R, 0, 1));
        cy.push_back(c(S_FETCH, OP_R, 0, 1)); cy.push_back(c(S_DECODE, OP_JAL, 0, 1));
        cy.push_back(c(S_EXEC, OP_STORE, 0, 1));
        foreach (cy[i]) begin
            drive(cy[i]);
            obs = outs(); exp = sb.pop_front(); vectors++;
            if (obs !== exp) begin errors++; $display("FAIL branch_jal[%0d]: got %b want %b", i, obs, exp); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal_then_imm();
        cyc_t cy[$];
        ctl_t obs, exp;
        cy.push_back(c(S_FETCH, OP_R, 0, 1)); cy.push_back(c(S_DECODE, OP_BAD, 0, 1));
        cy.push_back(c(S_FETCH, OP_R, 0, 1)); cy.push_back(c(S_DECODE, OP_IMM, 0, 1));
        cy.push_back(c(S_EXEC, OP_R, 0, 1));  cy.push_back(c(S_WB, OP_LOAD, 0, 1));
        cy.push_back(c(S_FETCH, OP_R, 0, 1)); cy.push_back(c(S_DECODE, OP_STORE, 0, 1));
        cy.push_back(c(S_EXEC, OP_R, 0, 1));  cy.push_back(c(S_MEM, OP_R, 0, 1));
        foreach (cy[i]) begin
            drive(cy[i]);
            obs = outs(); exp = sb.pop_front(); vectors++;
            if (obs !== exp) begin errors++; $display("FAIL illegal_imm_store[%0d]: got %b want %b", i, obs, exp); end
            @(posedge clk); #1;
        end
`ifdef CTRL_PERF_CNT_EN
        vectors++;
        if (retired_cnt !== 32'(exp_retired)) begin
            errors++; $display("FAIL retired_after_illegal: got %0d want %0d", retired_cnt, exp_retired);
        end
`endif
    endtask

    task automatic test_timeouts();
        cyc_t cy[$];
        ctl_t obs, exp;
        for (int k = 0; k < TIMEOUT; k++) cy.push_back(c(S_FETCH, OP_R, 0, 0));
        // Retry: one cycle short of timeout, then ready on the boundary cycle
        for (int k = 0; k < TIMEOUT - 1; k++) cy.push_back(c(S_FETCH, OP_R, 0, 0));
        cy.push_back(c(S_FETCH, OP_R, 0, 1)); cy.push_back(c(S_DECODE, OP_STORE, 0, 1));
        cy.push_back(c(S_EXEC, OP_R, 0, 1));
        for (int k = 0; k < TIMEOUT; k++) cy.push_back(c(S_MEM, OP_R, 0, 0));
        cy.push_back(c(S_FETCH, OP_R, 0, 1)); cy.push_back(c(S_DECODE, OP_R, 0, 1));
        cy.push_back(c(S_EXEC, OP_R, 0, 1));  cy.push_back(c(S_WB, OP_R, 0, 1));
        foreach (cy[i]) begin
            drive(cy[i]);
            obs = outs(); exp = sb.pop_front(); vectors++;
            if (obs !== exp) begin errors++; $display("FAIL timeouts[%0d]: got %b want %b", i, obs, exp); end
            @(posedge clk); #1;
        end
`ifdef CTRL_PERF_CNT_EN
        vectors++;
        if (retired_cnt !== 32'(exp_retired)) begin
            errors++; $display("FAIL retired_after_timeout: got %0d want %0d", retired_cnt, exp_retired);
        end
`endif
    endtask

    task automatic test_reset_mid_store();
        cyc_t cy[$];
        cyc_t cy2[$];
        ctl_t obs, exp;
        cy.push_back(c(S_FETCH, OP_R, 0, 1)); cy.push_back(c(S_DECODE, OP_STORE, 0, 1));
        cy.push_back(c(S_EXEC, OP_R, 0, 1));
        foreach (cy[i]) begin
            drive(cy[i]);
            obs = outs(); exp = sb.pop_front(); vectors++;
            if (obs !== exp) begin errors++; $display("FAIL reset_mid_pre[%0d]: got %b want %b", i, obs, exp); end
            @(posedge clk); #1;
        end
        drive(c(S_MEM, OP_R, 0, 0));
        obs = outs(); exp = sb.pop_front(); vectors++;
        if (obs !== exp) begin errors++; $display("FAIL reset_mid_mem: got %b want %b", obs, exp); end
        reset = 1'b1;
        #1;
        vectors++;
        if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL reset_mid_mem_write: got %b want 0", bus.mem_write); end
        obs = outs(); vectors++;
        if (obs !== ctl_t'(0)) begin errors++; $display("FAIL reset_mid_outputs: got %b want 0", obs); end
        model_reset();
        @(posedge clk); #1;
        cy2.push_back(c(S_IDLE, OP_STORE, 0, 1));
        cy2.push_back(c(S_IDLE, OP_R, 0, 1));   cy2.push_back(c(S_FETCH, OP_R, 0, 1));
        cy2.push_back(c(S_DECODE, OP_R, 0, 1)); cy2.push_back(c(S_EXEC, OP_R, 0, 1));
        cy2.push_back(c(S_WB, OP_R, 0, 1));
        foreach (cy2[i]) begin
            drive(cy2[i]);
            obs = outs(); exp = sb.pop_front(); vectors++;
            if (obs !== exp) begin errors++; $display("FAIL reset_mid_post[%0d]: got %b want %b", i, obs, exp); end
            @(posedge clk); #1;
            if (i == 0) begin
                reset = 1'b0;
`ifdef CTRL_PERF_CNT_EN
                vectors++;
                if (retired_cnt !== 32'd0) begin errors++; $display("FAIL reset_mid_retired: got %0d want 0", retired_cnt); end
`endif
            end
        end
`ifdef CTRL_PERF_CNT_EN
        vectors++;
        if (retired_cnt !== 32'(exp_retired)) begin
            errors++; $display("FAIL retired_final: got %0d want %0d", retired_cnt, exp_retired);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.opcode = 7'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_r_type();
        test_load_wait();
        test_branch_jal();
        test_illegal_then_imm();
        test_timeouts();
        test_reset_mid_store();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Multi-cycle sequencer for the RV32I datapath. It replaces the single-cycle opcode decoder with a state machine that walks each instruction through fetch, decode, execute, memory and writeback over several clocks. It drives the shared ALU, the unified instruction/data memory port, the register file, the PC and the IR, and waits on a memory-ready handshake with a bounded timeout.

## Interface
Parameters:
- TIMEOUT, 16: maximum cycles to wait for `mem_ready` in FETCH or MEM. Range 2..255.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- opcode  in  7  instruction[6:0] from the IR output.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current read or write.
- pc_write  out  1  load the PC.
- pc_src  out  1  0 = ALU result (PC+4); 1 = registered branch/jump target.
- ir_write  out  1  load the IR from memory read data.
- iord  out  1  memory address source: 0 = PC; 1 = ALU-out register.
- mem_read, mem_write  out  1  memory strobes.
- reg_write  out  1  register file write enable.
- wb_sel  out  2  writeback source: 00 = ALU-out; 01 = memory data; 10 = PC+4.
- alu_src_a  out  1  0 = PC; 1 = rs1.
- alu_src_b  out  2  00 = rs2; 01 = constant 4; 10 = immediate.
- alu_op  out  2  00 = add; 01 = sub/compare; 10 = funct-decoded.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- illegal_instr  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
- bus_err  out  1  one-cycle pulse when a memory wait times out.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB. State is registered. Outputs are a combinational function of state, the latched opcode `op_q`, `zero` and `mem_ready`.
- IDLE: all outputs 0. Moves to FETCH on the next cycle.
- FETCH:
  - Drives mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - When mem_ready=1, also drives ir_write=1, pc_write=1, pc_src=0, and moves to DECODE.
- DECODE:
  - Latches opcode into op_q.
  - Drives alu_src_a=0, alu_src_b=10, alu_op=00 so the datapath registers the branch/jump target. The PC has already advanced, so the datapath supplies the fetch-time PC (oldPC) on ALU input A.
  - Supported opcodes are 0110011, 0000011, 0010011, 0100011, 1100011 and 1101111. A supported opcode moves to EXEC.
  - Any other opcode pulses illegal_instr and instr_done and returns to FETCH with no writes.
- EXEC, per op_q:
  - R (0110011): alu_src_a=1, alu_src_b=00, alu_op=10; then WB.
  - I-ALU (0010011): alu_src_a=1, alu_src_b=10, alu_op=10; then WB.
  - Load/store: alu_src_a=1, alu_src_b=10, alu_op=00; then MEM.
  - Branch (1100011): alu_src_a=1, alu_src_b=00, alu_op=01. If zero=1, also pc_write=1, pc_src=1. Pulses instr_done; then FETCH.
  - JAL (1101111): pc_write=1, pc_src=1, reg_write=1, wb_sel=10. Pulses instr_done; then FETCH.
- MEM:
  - Load drives mem_read=1, iord=1. On mem_ready it moves to WB.
  - Store drives mem_write=1, iord=1. On mem_ready it pulses instr_done and moves to FETCH.
- WB: reg_write=1. wb_sel=01 for a load, 00 otherwise. Pulses instr_done; then FETCH.
- Wait counter:
  - 8-bit; clears on entry to FETCH or MEM; increments each cycle in that state while mem_ready=0.
  - If it reaches TIMEOUT-1 with mem_ready still 0, the FSM pulses bus_err and instr_done and goes to FETCH.
  - On timeout, ir_write, pc_write and reg_write stay 0, so the PC is unchanged and the fetch is retried.
- mem_ready and timeout in the same cycle: mem_ready wins and the transfer completes normally.

## Timing
- Reset asserted: the FSM is in IDLE immediately, all outputs 0, counter 0, op_q 0.
- After reset deasserts: first clock edge reaches FETCH.
- Cycles per instruction with mem_ready tied high: branch/JAL 3, R/I/store 4, load 5. Each cycle mem_ready is late adds one cycle.
- Reset mid-instruction: returns to IDLE at once; no partial write strobe survives past the reset edge.
- op_q changes only in DECODE. Changes on `opcode` during later states are ignored.
- bus_err, illegal_instr and instr_done are each high for exactly one cycle per event.

## Configuration
- `CTRL_PERF_CNT_EN` defined: adds output `retired_cnt` [31:0].
  - Increments on each instr_done that is not caused by bus_err or illegal_instr.
  - Wraps from 0xFFFFFFFF to 0; reset value 0.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Reset, then mem_ready=1 and opcode=0110011: states IDLE→FETCH→DECODE→EXEC→WB; reg_write=1 only in WB; instr_done on cycle 5 after reset release.
- Load (0000011) with mem_ready low for 3 cycles in MEM: mem_read and iord held for 4 MEM cycles, then WB with wb_sel=01; 8 cycles total.
- Branch (1100011): with zero=1, pc_write=1 and pc_src=1 in EXEC; with zero=0, pc_write=0. Both return to FETCH after 3 cycles.
- Opcode 1111111: illegal_instr pulses in DECODE; no reg_write, mem_write or pc_write; next state FETCH.
- mem_ready held 0 with TIMEOUT=16: bus_err pulses on the 16th FETCH cycle; pc_write stays 0; FETCH re-entered with counter 0.
- Reset asserted during MEM of a store: mem_write drops the same cycle; IDLE then FETCH; `retired_cnt` reads 0 when `CTRL_PERF_CNT_EN` is defined.
